ls_responder_ipa: RTL and testbench
===================================

# ls_responder_ipa

Memory-side responder for the tile load/store interface of the IPA CGRA. It collects the per-tile request lines (req, store/load select, byte address, store data) from all NB_ROWS*NB_COLS tiles and arbitrates them round-robin, one access per cycle. It executes each access against an internal word-addressed data memory and returns one-cycle grant pulses and load data with a per-tile valid strobe. A host port preloads and inspects the memory outside or between kernel executions.

## Interface

- NB_ROWS, 4, tile rows; NB_PORTS = NB_ROWS*NB_COLS
- NB_COLS, 4, tile columns
- MEM_AWIDTH, 10, log2 of memory depth in 32-bit words
- Clk  in  1  clock, all state on rising edge
- Reset  in  1  asynchronous, active-low reset
- Req_I  in  NB_PORTS  per-tile request; the tile holds it high until it sees its grant
- Store_I  in  NB_PORTS  per-tile select: 1 = store, 0 = load
- Addr_I  in  NB_PORTS*32  per-tile byte address; tile i owns bits [32i+31:32i]
- Store_Data_I  in  NB_PORTS*32  per-tile store data, same packing
- Grant_O  out  NB_PORTS  one-hot, one-cycle grant pulse
- Data_Req_Valid_O  out  NB_PORTS  one-hot load-data valid
- Load_Data_O  out  32  load data, shared by all tiles, qualified by Data_Req_Valid_O
- Host_En_I  in  1  host access this cycle
- Host_We_I  in  1  host access is a write (1) or a read (0)
- Host_Addr_I  in  MEM_AWIDTH  host word address
- Host_Wdata_I  in  32  host write data
- Host_Rdata_O  out  32  host read data, valid in the cycle after the host read
- Access_Count_O  out  32  number of tile accesses granted since reset
- Addr_Err_O  out  1  sticky out-of-range flag

## Operation

- Word index is Addr_I[MEM_AWIDTH+1:2]. Address bits [1:0] are ignored.
- An access is out of range when any of Addr_I[31:MEM_AWIDTH+2] is nonzero. Such an access is still granted and counted, and it sets Addr_Err_O.
  - Store: dropped.
  - Load: returns 0 with valid asserted.
- Eligible tiles are those with Req_I=1, excluding the tile granted in the previous cycle. That tile's request is still high during its grant cycle, and this mask prevents a double grant.
- Round-robin pointer rr, range 0..NB_PORTS-1, reset 0.
  - The winner is the first eligible tile scanning rr, rr+1, … with modulo wrap.
  - After a grant to tile i, rr becomes (i+1) mod NB_PORTS. rr does not change when no grant is issued.
- Host priority: when Host_En_I=1, no tile is granted that cycle and rr holds. The host reads or writes the memory at word Host_Addr_I.
- Access_Count_O increments by 1 per grant and wraps at 2^32.
- Memory contents are not reset. All other state is reset.

## Timing

- Reset values: Grant_O, Data_Req_Valid_O, Load_Data_O, Host_Rdata_O, Access_Count_O and Addr_Err_O are all 0. The previous-grant mask is empty and any in-flight load valid is cancelled.
- Edge E0: the winner is selected from inputs sampled at E0.
  - Grant_O[i] is high for exactly the cycle after E0 (cycle T0).
  - For a store, the memory is written at E0 with Store_Data_I sampled at E0.
- Load latency: the address is sampled at E0. Data_Req_Valid_O[i]=1 and Load_Data_O=mem[idx] during T1, the cycle after T0.
- Read-after-write: a store granted in cycle T0 followed by a load to the same word granted in the next cycle returns the new data.
- Throughput: one grant per cycle. A single requesting tile can be granted at most every other cycle because of the mask.
- Host read: Host_Rdata_O is valid in the cycle after Host_En_I=1, Host_We_I=0. Otherwise it holds its last value.
- Reset asserted mid-access: all outputs go to 0 asynchronously. A pending load valid is never emitted after reset is released.

## Test plan

- Host writes 0xDEADBEEF to word 5. Tile 3 loads Addr_I=0x14 -> Grant_O=0x0008 for 1 cycle, then Data_Req_Valid_O=0x0008 with Load_Data_O=0xDEADBEEF in the next cycle. Access_Count_O=1.
- Tiles 0, 1 and 15 hold requests from reset -> grants in order 0, 1, 15, 0, 1, 15. No tile is granted in two consecutive cycles.
- Tile 2 stores 0x12345678 to 0x40, then immediately loads 0x40 -> load returns 0x12345678.
- Host_En_I=1 while tiles 4 and 5 request -> no Grant_O that cycle. The grant goes to tile 4 once Host_En_I drops, and rr is unchanged by the host cycle.
- Tile 7 loads Addr_I=0x0001_0000 with MEM_AWIDTH=10 -> granted, Load_Data_O=0, Addr_Err_O=1 and remains 1 afterwards. A subsequent host read shows memory unchanged.
- Reset pulse in the cycle between a load grant and its data -> no Data_Req_Valid_O after release. rr=0 and Access_Count_O=0.

Source files
------------

// File: rtl/ls_responder_ipa.sv
// rtl/ls_responder_ipa.sv - round-robin tile load/store responder with host-accessible data memory
//
// Purpose: arbitrates the per-tile load/store requests of the CGRA one access
// per cycle, executes them against a word-addressed data memory and returns a
// one-cycle grant pulse plus, for loads, data with a per-tile valid strobe.
// A host port can read and write the memory; it has priority over the tiles.
//
// Ports:
//   Clk, Reset                  clock, asynchronous active-low reset
//   Req_I, Store_I              per-tile request and store(1)/load(0) select
//   Addr_I, Store_Data_I        per-tile byte address / store data, 32 bits per tile
//   Grant_O                     one-hot grant pulse, cycle after the arbitration edge
//   Data_Req_Valid_O            one-hot load-data valid, cycle after the grant
//   Load_Data_O                 load data shared by all tiles
//   Host_En_I, Host_We_I        host access enable and write select
//   Host_Addr_I, Host_Wdata_I   host word address and write data
//   Host_Rdata_O                host read data, cycle after the read
//   Access_Count_O              granted tile accesses since reset (wraps)
//   Addr_Err_O                  sticky out-of-range access flag
module ls_responder_ipa #(
    parameter int NB_ROWS    = 4,
    parameter int NB_COLS    = 4,
    parameter int MEM_AWIDTH = 10
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic [NB_ROWS*NB_COLS-1:0]      Req_I,
    input  logic [NB_ROWS*NB_COLS-1:0]      Store_I,
    input  logic [NB_ROWS*NB_COLS*32-1:0]   Addr_I,
    input  logic [NB_ROWS*NB_COLS*32-1:0]   Store_Data_I,
    output logic [NB_ROWS*NB_COLS-1:0]      Grant_O,
    output logic [NB_ROWS*NB_COLS-1:0]      Data_Req_Valid_O,
    output logic [31:0]                     Load_Data_O,
    input  logic                            Host_En_I,
    input  logic                            Host_We_I,
    input  logic [MEM_AWIDTH-1:0]           Host_Addr_I,
    input  logic [31:0]                     Host_Wdata_I,
    output logic [31:0]                     Host_Rdata_O,
    output logic [31:0]                     Access_Count_O,
    output logic                            Addr_Err_O
);

    localparam int NB_PORTS = NB_ROWS * NB_COLS;
    localparam int PW       = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
    localparam int DEPTH    = 1 << MEM_AWIDTH;

    logic [31:0]           mem [DEPTH];

    logic [PW-1:0]         rr;
    logic [31:0]           tile_addr  [NB_PORTS];
    logic [31:0]           tile_wdata [NB_PORTS];
    logic                  unused_addr_lsbs;

    logic [NB_PORTS-1:0]   eligible;
    logic [PW-1:0]         cand;
    logic                  win_found;
    logic [PW-1:0]         win_idx;
    logic [NB_PORTS-1:0]   win_onehot;
    logic [31:0]           win_addr;
    logic                  win_store;
    logic                  win_oor;
    logic [MEM_AWIDTH-1:0] win_word;
    logic                  grant_fire;

    // Load issued at the grant edge, data returned one edge later.
    logic                  ld_pend;
    logic [NB_PORTS-1:0]   ld_tile;
    logic [MEM_AWIDTH-1:0] ld_word;
    logic                  ld_oor;

    // (base + off) mod NB_PORTS for base, off < NB_PORTS.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input logic [PW-1:0] off);
        logic [PW:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (PW+1)'(NB_PORTS)) begin
            sum = sum - (PW+1)'(NB_PORTS);
        end
        return sum[PW-1:0];
    endfunction

    // Byte-lane bits of the addresses carry no meaning for word accesses.
    always_comb begin
        unused_addr_lsbs = 1'b0;
        for (int i = 0; i < NB_PORTS; i++) begin
            tile_addr[i]     = Addr_I[32*i +: 32];
            tile_wdata[i]    = Store_Data_I[32*i +: 32];
            unused_addr_lsbs = unused_addr_lsbs ^ (^tile_addr[i][1:0]);
        end
    end

    // The tile granted last cycle still holds Req_I high while it sees its
    // grant; masking it here keeps it from being granted twice.
    assign eligible = Req_I & ~Grant_O;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NB_PORTS; k++) begin
            cand = wrap_add(rr, PW'(k));
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_onehot = {{(NB_PORTS-1){1'b0}}, 1'b1} << win_idx;
    assign win_addr   = tile_addr[win_idx];
    assign win_store  = Store_I[win_idx];
    assign win_oor    = |win_addr[31:MEM_AWIDTH+2];
    assign win_word   = win_addr[MEM_AWIDTH+1:2];
    assign grant_fire = win_found && !Host_En_I;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rr               <= '0;
            Grant_O          <= '0;
            Data_Req_Valid_O <= '0;
            Load_Data_O      <= '0;
            Host_Rdata_O     <= '0;
            Access_Count_O   <= '0;
            Addr_Err_O       <= 1'b0;
            ld_pend          <= 1'b0;
            ld_tile          <= '0;
            ld_word          <= '0;
            ld_oor           <= 1'b0;
        end else begin
            Grant_O <= grant_fire ? win_onehot : '0;
            if (grant_fire) begin
                rr             <= wrap_add(win_idx, PW'(1));
                Access_Count_O <= Access_Count_O + 32'd1;
                if (win_oor) begin
                    Addr_Err_O <= 1'b1;
                end
            end

            ld_pend <= grant_fire && !win_store;
            ld_tile <= win_onehot;
            ld_word <= win_word;
            ld_oor  <= win_oor;

            Data_Req_Valid_O <= ld_pend ? ld_tile : '0;
            if (ld_pend) begin
                Load_Data_O <= ld_oor ? 32'd0 : mem[ld_word];
            end

            if (Host_En_I && !Host_We_I) begin
                Host_Rdata_O <= mem[Host_Addr_I];
            end
        end
    end

    // Host and tile writes never coincide: a host cycle suppresses grants.
    always_ff @(posedge Clk) begin
        if (Host_En_I && Host_We_I) begin
            mem[Host_Addr_I] <= Host_Wdata_I;
        end else if (grant_fire && win_store && !win_oor) begin
            mem[win_word] <= tile_wdata[win_idx];
        end
    end

endmodule

// File: tb/tb_ls_responder_ipa.sv
// tb/tb_ls_responder_ipa.sv - self-checking bench for ls_responder_ipa
module tb_ls_responder_ipa;

    localparam int NP    = 16;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic            Clk;
    logic            Reset;
    logic [NP-1:0]   Req_I;
    logic [NP-1:0]   Store_I;
    logic [NP*32-1:0] Addr_I;
    logic [NP*32-1:0] Store_Data_I;
    logic [NP-1:0]   Grant_O;
    logic [NP-1:0]   Data_Req_Valid_O;
    logic [31:0]     Load_Data_O;
    logic            Host_En_I;
    logic            Host_We_I;
    logic [AW-1:0]   Host_Addr_I;
    logic [31:0]     Host_Wdata_I;
    logic [31:0]     Host_Rdata_O;
    logic [31:0]     Access_Count_O;
    logic            Addr_Err_O;

    ls_responder_ipa #(.NB_ROWS(4), .NB_COLS(4), .MEM_AWIDTH(AW)) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .Req_I            (Req_I),
        .Store_I          (Store_I),
        .Addr_I           (Addr_I),
        .Store_Data_I     (Store_Data_I),
        .Grant_O          (Grant_O),
        .Data_Req_Valid_O (Data_Req_Valid_O),
        .Load_Data_O      (Load_Data_O),
        .Host_En_I        (Host_En_I),
        .Host_We_I        (Host_We_I),
        .Host_Addr_I      (Host_Addr_I),
        .Host_Wdata_I     (Host_Wdata_I),
        .Host_Rdata_O     (Host_Rdata_O),
        .Access_Count_O   (Access_Count_O),
        .Addr_Err_O       (Addr_Err_O)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;
    bit checking = 0;
    int grant_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural model: tiles, memory and expected outputs in plain integers.
    logic [31:0] m_mem [DEPTH];
    int          m_rr      = 0;
    int          m_prev    = -1;
    logic [31:0] m_count   = 0;
    logic        m_err     = 0;
    bit          pend_valid = 0;
    int          pend_tile  = 0;
    logic [31:0] pend_data  = 0;
    logic [NP-1:0] exp_grant = 0;
    logic [NP-1:0] exp_valid = 0;
    logic [31:0]   exp_ldata = 0;
    logic [31:0]   exp_hrd   = 0;

    task automatic model_reset();
        m_rr       = 0;
        m_prev     = -1;
        m_count    = 0;
        m_err      = 0;
        pend_valid = 0;
        exp_grant  = 0;
        exp_valid  = 0;
        exp_ldata  = 0;
        exp_hrd    = 0;
    endtask

    always @(posedge Clk or negedge Reset) begin : model
        int          win;
        int          t;
        int          idx;
        bit          oor;
        logic [31:0] a;
        if (!Reset) begin
            model_reset();
        end else begin
            exp_valid = pend_valid ? (NP'(1) << pend_tile) : '0;
            if (pend_valid) exp_ldata = pend_data;
            pend_valid = 0;
            win = -1;
            if (Host_En_I) begin
                if (Host_We_I) m_mem[Host_Addr_I] = Host_Wdata_I;
                else           exp_hrd = m_mem[Host_Addr_I];
            end else begin
                for (int k = 0; k < NP; k++) begin
                    t = (m_rr + k) % NP;
                    if (win < 0 && Req_I[t] && t != m_prev) win = t;
                end
            end
            exp_grant = (win >= 0) ? (NP'(1) << win) : '0;
            if (win >= 0) begin
                m_count = m_count + 1;
                m_rr    = (win + 1) % NP;
                a       = Addr_I[32*win +: 32];
                oor     = (a >> (AW + 2)) != 0;
                idx     = int'((a >> 2) % DEPTH);
                if (oor) m_err = 1;
                if (Store_I[win]) begin
                    if (!oor) m_mem[idx] = Store_Data_I[32*win +: 32];
                end else begin
                    pend_valid = 1;
                    pend_tile  = win;
                    pend_data  = oor ? 32'd0 : m_mem[idx];
                end
            end
            m_prev = win;
        end
    end

    always @(negedge Clk) begin
        if (checking) begin
            chk("grant", 32'(Grant_O), 32'(exp_grant));
            chk("valid", 32'(Data_Req_Valid_O), 32'(exp_valid));
            if (exp_valid != 0) chk("ldata", Load_Data_O, exp_ldata);
            chk("count", Access_Count_O, m_count);
            chk("err", 32'(Addr_Err_O), 32'(m_err));
            chk("hrdata", Host_Rdata_O, exp_hrd);
            for (int i = 0; i < NP; i++) if (Grant_O[i]) grant_log.push_back(i);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic set_tile(input int t, input logic r, input logic s, input logic [31:0] a, input logic [31:0] d);
        Req_I[t]               = r;
        Store_I[t]             = s;
        Addr_I[32*t +: 32]     = a;
        Store_Data_I[32*t +: 32] = d;
    endtask

    task automatic host_wr(input logic [AW-1:0] a, input logic [31:0] d);
        Host_En_I = 1; Host_We_I = 1; Host_Addr_I = a; Host_Wdata_I = d;
        tick();
        Host_En_I = 0; Host_We_I = 0;
    endtask

    int exp_order[6] = '{0, 1, 15, 0, 1, 15};

    initial begin
        Reset = 0; Req_I = '0; Store_I = '0; Addr_I = '0; Store_Data_I = '0;
        Host_En_I = 0; Host_We_I = 0; Host_Addr_I = '0; Host_Wdata_I = '0;
        repeat (3) @(posedge Clk);
        #2;
        chk("rst_grant", 32'(Grant_O), 32'd0);
        chk("rst_valid", 32'(Data_Req_Valid_O), 32'd0);
        chk("rst_ldata", Load_Data_O, 32'd0);
        chk("rst_hrdata", Host_Rdata_O, 32'd0);
        chk("rst_count", Access_Count_O, 32'd0);
        chk("rst_err", 32'(Addr_Err_O), 32'd0);
        Reset = 1;
        checking = 1;

        host_wr(10'd0, 32'hA5A5_A5A5);
        host_wr(10'd5, 32'hDEAD_BEEF);

        // Tiles 0, 1, 15 hold load requests.
        grant_log.delete();
        set_tile(0, 1, 0, 32'h0, 0);
        set_tile(1, 1, 0, 32'h0, 0);
        set_tile(15, 1, 0, 32'h0, 0);
        repeat (6) tick();
        Req_I = '0;
        tick();
        chk("rr_len", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk("rr_order", 32'(grant_log[i]), 32'(exp_order[i]));
        chk("rr_count", Access_Count_O, 32'd6);
        tick();

        // Tile 3 load of word 5.
        set_tile(3, 1, 0, 32'h14, 0);
        tick();
        chk("t1_grant", 32'(Grant_O), 32'h0008);
        Req_I[3] = 0;
        tick();
        chk("t1_valid", 32'(Data_Req_Valid_O), 32'h0008);
        chk("t1_data", Load_Data_O, 32'hDEAD_BEEF);
        chk("t1_count", Access_Count_O, 32'd7);
        tick();

        // Store by tile 2, then loads of the same word by tiles 10 and 2.
        set_tile(2, 1, 1, 32'h40, 32'h1234_5678);
        tick();
        chk("raw_sgrant", 32'(Grant_O), 32'h0004);
        set_tile(2, 1, 0, 32'h40, 0);
        set_tile(10, 1, 0, 32'h40, 0);
        tick();
        chk("raw_lgrant", 32'(Grant_O), 32'h0400);
        Req_I[10] = 0;
        tick();
        chk("raw_valid10", 32'(Data_Req_Valid_O), 32'h0400);
        chk("raw_data10", Load_Data_O, 32'h1234_5678);
        chk("raw_grant2", 32'(Grant_O), 32'h0004);
        Req_I[2] = 0;
        tick();
        chk("raw_data2", Load_Data_O, 32'h1234_5678);
        tick();

        // Host priority over tiles 4 and 5.
        set_tile(4, 1, 0, 32'h0, 0);
        set_tile(5, 1, 0, 32'h0, 0);
        Host_En_I = 1; Host_We_I = 0; Host_Addr_I = 10'd5;
        tick();
        chk("host_nogrant", 32'(Grant_O), 32'd0);
        chk("host_rdata", Host_Rdata_O, 32'hDEAD_BEEF);
        Host_En_I = 0;
        tick();
        chk("host_grant4", 32'(Grant_O), 32'h0010);
        Req_I[4] = 0;
        tick();
        chk("host_grant5", 32'(Grant_O), 32'h0020);
        Req_I[5] = 0;
        tick();

        // Out-of-range load and store by tile 7.
        set_tile(7, 1, 0, 32'h0001_0000, 0);
        tick();
        chk("oor_grant", 32'(Grant_O), 32'h0080);
        Req_I[7] = 0;
        tick();
        chk("oor_valid", 32'(Data_Req_Valid_O), 32'h0080);
        chk("oor_data", Load_Data_O, 32'd0);
        chk("oor_err", 32'(Addr_Err_O), 32'd1);
        set_tile(7, 1, 1, 32'h0001_0000, 32'hFFFF_FFFF);
        tick();
        chk("oor_sgrant", 32'(Grant_O), 32'h0080);
        set_tile(7, 0, 0, 32'h0, 0);
        Host_En_I = 1; Host_We_I = 0; Host_Addr_I = 10'd0;
        tick();
        Host_En_I = 0;
        chk("oor_mem", Host_Rdata_O, 32'hA5A5_A5A5);
        chk("oor_sticky", 32'(Addr_Err_O), 32'd1);
        chk("oor_count", Access_Count_O, 32'd14);
        tick();

        // Reset between a load grant and its data.
        set_tile(7, 1, 0, 32'h14, 0);
        tick();
        chk("mid_grant", 32'(Grant_O), 32'h0080);
        Req_I[7] = 0;
        Reset = 0;
        #1;
        chk("mid_rgrant", 32'(Grant_O), 32'd0);
        chk("mid_rcount", Access_Count_O, 32'd0);
        chk("mid_rerr", 32'(Addr_Err_O), 32'd0);
        tick();
        Reset = 1;
        tick();
        chk("mid_novalid", 32'(Data_Req_Valid_O), 32'd0);
        set_tile(3, 1, 0, 32'h14, 0);
        set_tile(12, 1, 0, 32'h14, 0);
        tick();
        chk("mid_rr0", 32'(Grant_O), 32'h0008);
        Req_I[3] = 0;
        tick();
        chk("mid_grant12", 32'(Grant_O), 32'h1000);
        chk("mid_data", Load_Data_O, 32'hDEAD_BEEF);
        Req_I[12] = 0;
        tick();
        chk("mid_count", Access_Count_O, 32'd2);
        tick();

        checking = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
